// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: owns pc, instruction register, state and retire count.
// Optional single-step gating of FETCH is enabled with the FETCH_SEQUENCER_STEP_EN macro.
module fetch_sequencer (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FETCH_SEQUENCER_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] ram_q,
    input  logic        pc_sload,
    input  logic        pc_cnt_en,
    input  logic [15:0] pc_load_value,
    input  logic        sm_extra,
    input  logic        stop,
    input  logic        resume,
    output logic [1:0]  state,
    output logic [15:0] instruction,
    output logic [15:0] pc,
    output logic        halted,
    output logic [15:0] instr_retired
);

    localparam int unsigned W = 16;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC1 = 2'b01,
        S_EXEC2 = 2'b10,
        S_HALT  = 2'b11
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [W-1:0]   ir_q, ir_d;
    logic [W-1:0]   ret_q, ret_d;
    logic           step_ok;
    logic           pc_upd;
    logic           in_exec;

`ifdef FETCH_SEQUENCER_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    // Next-state, pc, IR and retire-count computation.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ret_d   = ret_q;
        pc_upd  = 1'b0;
        in_exec = (state_q == S_EXEC1) || (state_q == S_EXEC2);

        case (state_q)
            S_FETCH: begin
                if (stop)         state_d = S_HALT;
                else if (step_ok) state_d = S_EXEC1;
                if (step_ok) begin
                    ir_d   = ram_q;
                    pc_upd = 1'b1;
                end
            end
            S_EXEC1: begin
                pc_upd = 1'b1;
                if (stop)          state_d = S_HALT;
                else if (sm_extra) state_d = S_EXEC2;
                else               state_d = S_FETCH;
            end
            S_EXEC2: begin
                pc_upd = 1'b1;
                if (stop) state_d = S_HALT;
                else      state_d = S_FETCH;
            end
            S_HALT: begin
                if (resume && !stop) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (pc_upd) begin
            if (pc_sload)       pc_d = pc_load_value;
            else if (pc_cnt_en) pc_d = pc_q + W'(1);
        end

        // An instruction completes when an EXEC state leaves for FETCH or HALT.
        if (in_exec && (state_d != S_EXEC2)) ret_d = ret_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ret_q   <= ret_d;
        end
    end

    assign state         = state_q;
    assign pc            = pc_q;
    assign instruction   = ir_q;
    assign instr_retired = ret_q;
    assign halted        = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed cycles push expected outputs, a monitor compares.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ram_q = '0;
    logic        pc_sload = 1'b0;
    logic        pc_cnt_en = 1'b0;
    logic [15:0] pc_load_value = '0;
    logic        sm_extra = 1'b0;
    logic        stop = 1'b0;
    logic        resume = 1'b0;
`ifdef FETCH_SEQUENCER_STEP_EN
    logic        step = 1'b1;
`endif
    logic [1:0]  state;
    logic [15:0] instruction;
    logic [15:0] pc;
    logic        halted;
    logic [15:0] instr_retired;

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] ret;
        logic        hlt;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    fetch_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef FETCH_SEQUENCER_STEP_EN
        .step          (step),
`endif
        .ram_q         (ram_q),
        .pc_sload      (pc_sload),
        .pc_cnt_en     (pc_cnt_en),
        .pc_load_value (pc_load_value),
        .sm_extra      (sm_extra),
        .stop          (stop),
        .resume        (resume),
        .state         (state),
        .instruction   (instruction),
        .pc            (pc),
        .halted        (halted),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    // Monitor: after every clock edge or reset assertion, compare against the oldest expectation.
    initial begin
        obs_t  e, a;
        string n;
        forever begin
            @(posedge clk or negedge rst_n);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = '{st: state, pc: pc, ir: instruction, ret: instr_retired, hlt: halted};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got st=%b pc=%h ir=%h ret=%h hlt=%b, want st=%b pc=%h ir=%h ret=%h hlt=%b",
                             n, a.st, a.pc, a.ir, a.ret, a.hlt, e.st, e.pc, e.ir, e.ret, e.hlt);
                end
            end
        end
    end

    task automatic expect_obs(input string n, input logic [1:0] st, input logic [15:0] p,
                              input logic [15:0] ir, input logic [15:0] ret);
        obs_t e;
        e = '{st: st, pc: p, ir: ir, ret: ret, hlt: (st == 2'b11)};
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // Drive one cycle's inputs at the falling edge and record the state expected after the next rising edge.
    task automatic cyc(input string n, input logic [15:0] ram, input logic sl, input logic ce,
                       input logic [15:0] lv, input logic ex, input logic sp, input logic rs,
                       input logic [1:0] st, input logic [15:0] p, input logic [15:0] ir,
                       input logic [15:0] ret);
        @(negedge clk);
        ram_q = ram; pc_sload = sl; pc_cnt_en = ce; pc_load_value = lv;
        sm_extra = ex; stop = sp; resume = rs;
        expect_obs(n, st, p, ir, ret);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        expect_obs("reset_state", 2'b00, 16'h0000, 16'h0000, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Two-cycle instruction with pc incrementing in FETCH and EXEC1.
        cyc("r032_fetch", 16'h4011, 0, 1, 16'h0000, 0, 0, 0, 2'b01, 16'h0001, 16'h4011, 16'h0000);
        cyc("r032_exec1", 16'h0000, 0, 1, 16'h0000, 0, 0, 0, 2'b00, 16'h0002, 16'h4011, 16'h0001);

        // Three-cycle instruction via EXEC2.
        cyc("r033_fetch", 16'hA5A5, 0, 1, 16'h0000, 0, 0, 0, 2'b01, 16'h0003, 16'hA5A5, 16'h0001);
        cyc("r033_exec1", 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 2'b10, 16'h0003, 16'hA5A5, 16'h0001);
        cyc("r033_exec2", 16'h0000, 0, 1, 16'h0000, 0, 0, 0, 2'b00, 16'h0004, 16'hA5A5, 16'h0002);

        // Load has priority over increment.
        cyc("r035_fetch", 16'h1111, 0, 0, 16'h0000, 0, 0, 0, 2'b01, 16'h0004, 16'h1111, 16'h0002);
        cyc("r035_load",  16'h0000, 1, 1, 16'h1234, 0, 0, 0, 2'b00, 16'h1234, 16'h1111, 16'h0003);

        // pc wraps FFFF -> 0000.
        cyc("wrap_fetch", 16'h2222, 1, 0, 16'hFFFF, 0, 0, 0, 2'b01, 16'hFFFF, 16'h2222, 16'h0003);
        cyc("wrap_exec1", 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 16'hFFFF, 16'h2222, 16'h0004);
        cyc("r034_wrap",  16'h3333, 0, 1, 16'h0000, 0, 0, 0, 2'b01, 16'h0000, 16'h3333, 16'h0004);
        cyc("set_pc10",   16'h0000, 1, 0, 16'h0010, 0, 0, 0, 2'b00, 16'h0010, 16'h3333, 16'h0005);

        // Halt from EXEC1 still applies the pc increment and retires the instruction.
        cyc("r036_fetch", 16'h4444, 0, 0, 16'h0000, 0, 0, 0, 2'b01, 16'h0010, 16'h4444, 16'h0005);
        cyc("r036_stop",  16'h0000, 0, 1, 16'h0000, 0, 1, 0, 2'b11, 16'h0011, 16'h4444, 16'h0006);
        for (int i = 0; i < 5; i++)
            cyc("halt_idle", 16'h5555, 1, 1, 16'hBEEF, 1, 0, 0, 2'b11, 16'h0011, 16'h4444, 16'h0006);
        cyc("halt_stop_wins", 16'h5555, 0, 1, 16'h0000, 0, 1, 1, 2'b11, 16'h0011, 16'h4444, 16'h0006);
        cyc("resume",     16'h0000, 0, 0, 16'h0000, 0, 0, 1, 2'b00, 16'h0011, 16'h4444, 16'h0006);

        // Halt straight from FETCH does not retire; neither does resume.
        cyc("fetch_halt", 16'h4444, 0, 1, 16'h0000, 0, 1, 0, 2'b11, 16'h0012, 16'h4444, 16'h0006);
        cyc("resume2",    16'h0000, 0, 0, 16'h0000, 0, 0, 1, 2'b00, 16'h0012, 16'h4444, 16'h0006);

        // Asynchronous reset in EXEC2 abandons the instruction without retiring it.
        cyc("pre_rst_f",  16'h7777, 0, 0, 16'h0000, 0, 0, 0, 2'b01, 16'h0012, 16'h7777, 16'h0006);
        cyc("pre_rst_e1", 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 2'b10, 16'h0012, 16'h7777, 16'h0006);
        @(negedge clk);
        sm_extra = 1'b0;
        #1 rst_n = 1'b0;
        expect_obs("r037_async_rst", 2'b00, 16'h0000, 16'h0000, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc("post_rst_f", 16'h8888, 0, 1, 16'h0000, 0, 0, 0, 2'b01, 16'h0001, 16'h8888, 16'h0000);
        cyc("post_rst_e", 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 16'h0001, 16'h8888, 16'h0001);

`ifdef FETCH_SEQUENCER_STEP_EN
        // With step low FETCH holds and ignores pc controls.
        for (int i = 0; i < 3; i++) begin
            cyc("step_hold", 16'h9999, 1, 1, 16'hABCD, 0, 0, 0, 2'b00, 16'h0001, 16'h8888, 16'h0001);
            step = 1'b0;
        end
        cyc("step_go_pre", 16'h9999, 0, 1, 16'h0000, 0, 0, 0, 2'b00, 16'h0001, 16'h8888, 16'h0001);
        @(negedge clk);
        step = 1'b1;
        exp_q.delete(exp_q.size() - 1);
        name_q.delete(name_q.size() - 1);
        expect_obs("step_go", 2'b01, 16'h0002, 16'h9999, 16'h0001);
        @(negedge clk);
        pc_cnt_en = 1'b0; ram_q = '0;
        expect_obs("step_exec1", 2'b00, 16'h0002, 16'h9999, 16'h0002);
`endif

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 ram_q  in  16  instruction word read from instruction RAM at address pc; valid during FETCH.
REQ-004 pc_sload  in  1  load pc from pc_load_value (from decoder).
REQ-005 pc_cnt_en  in  1  increment pc (from decoder).
REQ-006 pc_load_value  in  16  jump/call/return target from datapath mux.
REQ-007 sm_extra  in  1  current instruction needs EXEC2 (from decoder).
REQ-008 stop  in  1  halt request (from decoder).
REQ-009 resume  in  1  leave HALT.
REQ-010 state  out  2  sequencer state to decoder: 00 FETCH, 01 EXEC1, 10 EXEC2, 11 HALT.
REQ-011 instruction  out  16  instruction register (IR) driving the decoder.
REQ-012 pc  out  16  program counter, instruction RAM address.
REQ-013 halted  out  1  high exactly when state is HALT.
REQ-014 instr_retired  out  16  count of completed instructions.

Function
REQ-015 The transitions SHALL be FETCH->EXEC1; EXEC1->EXEC2 if sm_extra else EXEC1->FETCH; EXEC2->FETCH; HALT->FETCH when resume=1.
REQ-016 stop=1 in FETCH, EXEC1 or EXEC2 SHALL force next state HALT, overriding every other transition.
REQ-017 In HALT, stop=1 SHALL keep HALT even when resume=1.
REQ-018 IR SHALL load ram_q at the clock edge ending a FETCH cycle and hold in all other states.
REQ-019 pc SHALL be updated outside HALT as follows: pc_sload=1 -> pc_load_value (priority over pc_cnt_en); else pc_cnt_en=1 -> pc+1 modulo 2^16 (FFFF->0000); else hold.
REQ-020 The pc update SHALL still apply in the cycle stop is sampled, so resume continues at the next instruction.
REQ-021 In HALT, pc_sload and pc_cnt_en SHALL be ignored, and pc and IR SHALL hold.
REQ-022 instr_retired SHALL increment by 1 (wrapping FFFF->0000) on every transition EXEC1->FETCH, EXEC2->FETCH, EXEC1->HALT or EXEC2->HALT.
REQ-023 instr_retired SHALL NOT increment on FETCH->HALT or HALT->FETCH.
REQ-024 state, pc and instruction SHALL be registered outputs; halted SHALL be decoded from the state register with no input path.
REQ-025 Instruction latency SHALL be 2 cycles (FETCH, EXEC1), or 3 cycles when sm_extra=1 in EXEC1.

Reset
REQ-026 While rst_n=0, the block SHALL immediately hold state=00 (FETCH), pc=0000, instruction=0000, instr_retired=0000 and halted=0.
REQ-027 Reset asserted mid-instruction (EXEC1/EXEC2) or in HALT SHALL abandon it with no retire count.
REQ-028 After rst_n deasserts, the first rising edge SHALL be a FETCH cycle at pc=0000.

Configuration
REQ-029 The macro FETCH_SEQUENCER_STEP_EN, when defined, SHALL add input step (1 bit); FETCH->EXEC1 and the FETCH IR load then occur only in cycles with step=1.
REQ-030 With FETCH_SEQUENCER_STEP_EN defined and step=0 in FETCH, the block SHALL stay in FETCH and hold pc and IR, ignoring pc_cnt_en and pc_sload; stop SHALL still force HALT.
REQ-031 Without FETCH_SEQUENCER_STEP_EN, the step port SHALL be absent and FETCH SHALL always advance after one cycle.

Verification
REQ-032 Reset, then ram_q=0x4011, pc_cnt_en=1 in FETCH and EXEC1, sm_extra=0 -> state 00,01,00; IR=0x4011; pc=0002; instr_retired=1.
REQ-033 sm_extra=1 in EXEC1, pc_cnt_en=1 only in FETCH and EXEC2 -> states 00,01,10,00; pc advances by 2; instr_retired=1.
REQ-034 pc=FFFF, pc_cnt_en=1 in FETCH -> pc=0000 next cycle.
REQ-035 EXEC1 with pc_sload=1, pc_cnt_en=1, pc_load_value=0x1234 -> pc=1234.
REQ-036 stop=1 and pc_cnt_en=1 in EXEC1 at pc=0010 -> state=11, halted=1, pc=0011; 5 idle cycles hold all outputs; resume=1 with stop=1 -> stays HALT; resume=1 with stop=0 -> FETCH at pc=0011.
REQ-037 rst_n low during EXEC2 -> all outputs reset immediately without a clock edge; with the macro defined, step=0 holds FETCH for 3 cycles with pc unchanged.
